// File: rtl/opl3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : opl3_pkg
// Purpose  : Shared types and defaults for the OPL3 register-write path.
// Revision : 1.0 - initial release
// ============================================================================
package opl3_pkg;

    typedef struct packed {
        logic       valid;
        logic       bank_num;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    localparam int REG_WR_FIFO_DEPTH = 16;
    localparam int REG_WR_MIN_GAP    = 0;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/opl3_reg_wr_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module   : reg_wr_fifo
// Purpose  : Single-clock show-ahead FIFO holding {bank, address, data}.
// Revision : 1.0 - initial release
// ============================================================================
module reg_wr_fifo import opl3_pkg::*; #(
    parameter int DEPTH = REG_WR_FIFO_DEPTH,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign full     = (r_level == c_FULL);
    assign empty    = (r_level == '0);
    assign level    = r_level;
    assign pop_data = r_mem[r_rd_ptr];
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/opl3_reg_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : opl3_reg_wr_sched
// Purpose  : Buffers host register writes and issues them one per slot onto
//            the OPL3 register bus, after an optional zero sweep of all regs.
// Revision : 1.0 - initial release
// ============================================================================
module opl3_reg_wr_sched import opl3_pkg::*; #(
    parameter int FIFO_DEPTH    = REG_WR_FIFO_DEPTH,
    parameter int MIN_GAP       = REG_WR_MIN_GAP,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic                          host_bank,
    input  logic [7:0]                    host_address,
    input  logic [7:0]                    host_data,
    input  logic                          hold,
    output opl3_reg_wr_t                  opl3_reg_wr,
    output logic                          init_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [3:0]   c_MIN_GAP     = 4'(MIN_GAP);
    localparam sched_state_t c_RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;

    sched_state_t r_state;
    sched_state_t w_next_state;
    logic [8:0]   r_sweep_addr;
    logic [3:0]   r_gap_cnt;
    opl3_reg_wr_t r_bus;
    logic         w_sweep_wr;
    logic         w_issue;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic [16:0]  w_head;

    assign host_ready  = !reset && !w_full;
    assign w_push      = host_valid && host_ready;
    assign init_busy   = (r_state == ST_INIT);
    assign opl3_reg_wr = r_bus;

    reg_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (17)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({host_bank, host_address, host_data}),
        .pop       (w_issue),
        .pop_data  (w_head),
        .level     (fifo_level),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The sweep reuses the gap counter for spacing and never looks at hold.
    always_comb begin
        w_next_state = r_state;
        w_sweep_wr   = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_gap_cnt == 4'd0) begin
                    w_sweep_wr = 1'b1;
                    if (r_sweep_addr == 9'h1FF) begin
                        w_next_state = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (!w_empty && !hold) begin
                    w_issue = 1'b1;
                    if (c_MIN_GAP != 4'd0) begin
                        w_next_state = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gap_cnt <= 4'd1) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = c_RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sweep_addr <= '0;
            r_gap_cnt    <= '0;
            r_bus        <= '0;
        end else begin
            r_bus.valid <= 1'b0;
            if (w_sweep_wr) begin
                r_bus        <= '{valid: 1'b1, bank_num: r_sweep_addr[8],
                                  address: r_sweep_addr[7:0], data: 8'h00};
                r_sweep_addr <= r_sweep_addr + 1'b1;
                r_gap_cnt    <= c_MIN_GAP;
            end else if (w_issue) begin
                r_bus     <= {1'b1, w_head};
                r_gap_cnt <= c_MIN_GAP;
            end else if (r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_opl3_reg_wr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_opl3_reg_wr_sched
// Purpose  : Self-checking bench for the register-write scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opl3_reg_wr_sched;
    import opl3_pkg::*;

    logic         clk;
    logic         reset, host_valid, host_bank, hold;
    logic [7:0]   host_address, host_data;
    logic         host_ready, init_busy;
    logic [4:0]   fifo_level;
    opl3_reg_wr_t dut_bus;

    logic         g_reset, g_valid, g_bank, g_hold;
    logic [7:0]   g_address, g_data;
    logic         g_ready, g_init_busy;
    logic [4:0]   g_level;
    opl3_reg_wr_t g_bus;

    int checks = 0;
    int errors = 0;

    logic [16:0] mq[$];
    logic [16:0] gq[$];
    bit          minit;
    logic [9:0]  midx;
    logic [17:0] mbus;

    opl3_reg_wr_sched #(.FIFO_DEPTH(16), .MIN_GAP(0), .INIT_ON_RESET(1)) dut (
        .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
        .host_bank(host_bank), .host_address(host_address), .host_data(host_data),
        .hold(hold), .opl3_reg_wr(dut_bus), .init_busy(init_busy), .fifo_level(fifo_level)
    );

    opl3_reg_wr_sched #(.FIFO_DEPTH(16), .MIN_GAP(3), .INIT_ON_RESET(0)) dut_g (
        .clk(clk), .reset(g_reset), .host_valid(g_valid), .host_ready(g_ready),
        .host_bank(g_bank), .host_address(g_address), .host_data(g_data),
        .hold(g_hold), .opl3_reg_wr(g_bus), .init_busy(g_init_busy), .fifo_level(g_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one edge of the scheduler described as queue operations.
    task automatic step();
        bit          do_push;
        logic [16:0] pushed;
        if (reset) begin
            @(posedge clk); #1;
            mq.delete();
            minit = (1'b1);
            midx  = '0;
            mbus  = '0;
        end else begin
            do_push = host_valid && (mq.size() < 16);
            pushed  = {host_bank, host_address, host_data};
            if (minit) begin
                mbus = {1'b1, midx[8], midx[7:0], 8'h00};
                midx = midx + 10'd1;
                if (midx == 10'd512) minit = 1'b0;
            end else if (mq.size() > 0 && !hold) begin
                mbus = {1'b1, mq.pop_front()};
            end else begin
                mbus[17] = 1'b0;
            end
            if (do_push) mq.push_back(pushed);
            @(posedge clk); #1;
        end
        chk("bus", 32'(dut_bus), 32'(mbus));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("host_ready", 32'(host_ready), 32'(!reset && (mq.size() < 16)));
        chk("init_busy", 32'(init_busy), 32'(minit));
    endtask

    task automatic rand_payload();
        host_bank    = 1'($urandom_range(0, 1));
        host_address = 8'($urandom_range(0, 255));
        host_data    = 8'($urandom_range(0, 255));
    endtask

    initial begin
        int n_pulse;
        int last;
        logic [16:0] gexp;
        reset = 1'b1; host_valid = 1'b0; hold = 1'b0;
        host_bank = 1'b0; host_address = 8'h00; host_data = 8'h00;
        g_reset = 1'b1; g_valid = 1'b0; g_hold = 1'b0;
        g_bank = 1'b0; g_address = 8'h00; g_data = 8'h00;
        minit = 1'b1; midx = '0; mbus = '0;

        // Reset, including a push attempt that must be refused.
        step();
        host_valid = 1'b1;
        step();
        reset = 1'b0; host_valid = 1'b0; hold = 1'b1;

        // Sweep with one host write queued, then reset at sweep address 0x080.
        while (midx < 10'd129) begin
            host_valid = (midx == 10'd5);
            host_bank = 1'b1; host_address = 8'h33; host_data = 8'hA5;
            step();
        end
        host_valid = 1'b0;
        chk("sweep_at_080", 32'(dut_bus.address), 32'h80);
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Full sweep; hold is high and must not stall it.
        while (minit) begin
            host_valid = (midx == 10'd300);
            rand_payload();
            step();
        end
        host_valid = 1'b0; hold = 1'b0;
        step();
        step();

        // Two-cycle latency from handshake to bus.
        host_valid = 1'b1; host_bank = 1'b1; host_address = 8'h05; host_data = 8'h01;
        step();
        host_valid = 1'b0;
        step();
        chk("latency_write", 32'(dut_bus), 32'h30501);

        // Fill under hold, 17th push refused, then drain in order.
        hold = 1'b1;
        repeat (17) begin
            host_valid = 1'b1;
            rand_payload();
            step();
        end
        chk("full_ready_low", 32'(host_ready), 32'h0);
        chk("full_level", 32'(fifo_level), 32'd16);
        host_valid = 1'b0; hold = 1'b0;
        repeat (17) step();

        // Hold rising in the cycle an issue is registered.
        hold = 1'b1;
        repeat (3) begin
            host_valid = 1'b1;
            rand_payload();
            step();
        end
        host_valid = 1'b0; hold = 1'b0;
        step();
        hold = 1'b1;
        chk("hold_issue_done", 32'(dut_bus.valid), 32'h1);
        step();
        step();
        hold = 1'b0;
        repeat (3) step();

        // Random traffic.
        repeat (400) begin
            host_valid = 1'($urandom_range(0, 1));
            hold = ($urandom_range(0, 3) == 0);
            rand_payload();
            step();
        end
        host_valid = 1'b0; hold = 1'b0;
        repeat (20) step();

        // Spacing with MIN_GAP = 3 and no sweep.
        @(posedge clk); #1;
        chk("g_reset_busy", 32'(g_init_busy), 32'h0);
        chk("g_reset_bus", 32'(g_bus), 32'h0);
        chk("g_reset_ready", 32'(g_ready), 32'h0);
        g_reset = 1'b0; g_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            g_bank = 1'($urandom_range(0, 1));
            g_address = 8'($urandom_range(0, 255));
            g_data = 8'($urandom_range(0, 255));
            gq.push_back({g_bank, g_address, g_data});
            g_valid = 1'b1;
            @(posedge clk); #1;
        end
        g_valid = 1'b0;
        chk("g_level", 32'(g_level), 32'd4);
        g_hold = 1'b0;
        n_pulse = 0;
        last = -1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (g_bus.valid) begin
                gexp = (gq.size() > 0) ? gq.pop_front() : 17'h0;
                chk("g_payload", 32'(g_bus[16:0]), 32'(gexp));
                if (last >= 0) chk("g_spacing", 32'(c - last), 32'd4);
                last = c;
                n_pulse++;
            end
        end
        chk("g_pulse_count", 32'(n_pulse), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
